dpram_be: RTL and testbench
===========================

# dpram_be

Parametrised successor to the dual-port RAM primitive: true dual-port memory with per-lane byte enables, registered and optionally pipelined reads with valid strobes, selectable read-during-write behaviour and deterministic same-address write-collision arbitration with a collision monitor. It is the storage core for the next-generation FIFO and any shared-buffer block needing synchronous, timing-friendly RAM.

## Interface
- DATA, 16, word width; must be a multiple of BYTE
- ADDR, 5, address width; depth = 2**ADDR
- BYTE, 8, lane width; LANES = DATA/BYTE
- RDW_MODE, 0, same-port read-during-write: 0 = read-first (old word), 1 = write-first (merged new word)
- OUT_REG, 1, extra output register stage: 0 or 1; read latency = 1 + OUT_REG
- COLL_PRIO, 0, same-address same-lane write winner: 0 = port A, 1 = port B

Ports:
- clK  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- a_port_EN  in  1  port A access enable (read, or write when a_port_WR=1)
- a_port_WR  in  1  port A write qualifier
- a_port_BE  in  LANES  port A byte-lane write enables
- a_port_ADDR  in  ADDR  port A address
- a_port_data_IN  in  DATA  port A write data
- a_port_data_OUT  out  DATA  port A read data, registered
- a_port_VALID  out  1  port A read data valid, one-cycle pulse per access
- b_port_EN, b_port_WR, b_port_BE, b_port_ADDR, b_port_data_IN, b_port_data_OUT, b_port_VALID: same as port A
- coll_FLAG  out  1  one-cycle pulse: both ports wrote the same address in the same cycle
- coll_COUNT  out  16  saturating count of collisions

## Operation
- Access on a port when EN=1; write when EN=1 and WR=1; lanes with BE[i]=0 keep their contents. EN=0: no read, no write, VALID=0 for that slot.
- Every enabled access (read or write) returns a word and a VALID pulse after the latency.
- Same-port write + read: RDW_MODE=0 returns pre-write word; RDW_MODE=1 returns old bytes on BE=0 lanes and new bytes on BE=1 lanes.
- Cross-port read of an address written by the other port in the same cycle: always returns pre-write word.
- Collision (both write, same address): per lane, if only one port enables the lane it wins; if both, COLL_PRIO port wins. Non-winning port's read data follows its own RDW_MODE view of its own write. coll_FLAG pulses if any lane overlaps or not (address match and both writing is sufficient).
- coll_COUNT increments once per collision, saturates at 16'hFFFF.
- Reset: data_OUT and pipeline registers to 0, VALID to 0, coll_FLAG 0, coll_COUNT 0. Memory contents are not reset and stay intact across reset.

## Timing
- Access sampled at edge N; OUT_REG=0: data/VALID at edge N+1; OUT_REG=1: at edge N+2.
- Back-to-back accesses every cycle, fully pipelined, no stalls, no backpressure.
- Write visible to a read on either port sampled at edge N+1 or later.
- data_OUT holds last value while VALID=0.
- coll_FLAG asserted in cycle after the colliding edge; coll_COUNT updates same edge.
- rst_n assertion mid-pipeline: in-flight reads dropped, VALID low immediately (asynchronous); write sampled on the same edge as reset deassertion is performed, access ignored while rst_n=0.

## Structure
- Package dpram_pkg: RDW_READ_FIRST/RDW_WRITE_FIRST and PRIO_A/PRIO_B constants, lane-merge function (old, new, be).
- Sub-module dpram_out_pipe: per-port data/valid register stage with async-low reset, instantiated twice, bypassed when OUT_REG=0.
- Top holds memory array, lane write logic, collision detect and counter.

## Test plan
- Reset then write A addr 3 = 16'hBEEF, read B addr 3 next cycle -> b_port_data_OUT 16'hBEEF, b_port_VALID one pulse at latency 2 (OUT_REG=1).
- Preload addr 5 = 16'h1234; A writes 16'hABCD BE=2'b01 -> reads 16'h12CD; repeat with RDW_MODE=1 same-cycle read -> 16'h12CD, RDW_MODE=0 -> 16'h1234.
- A and B write addr 7 same cycle, A=16'hAAAA BE=11, B=16'h5555 BE=11, COLL_PRIO=0 -> addr 7 = 16'hAAAA, coll_FLAG one pulse, coll_COUNT=1; with A BE=10, B BE=01 -> 16'hAA55.
- Cross-port: A writes addr 9 = 16'h0F0F while B reads addr 9 (old 16'h0000) -> B gets 16'h0000, next read 16'h0F0F.
- Streaming: 32 consecutive reads on both ports -> 32 VALID pulses each, data in order, no gaps.
- Assert rst_n with 2 reads in flight -> VALID low immediately, no stale pulses after release; earlier-written memory contents unchanged; force 65 536 collisions -> coll_COUNT holds 16'hFFFF.

Source files
------------

// File: rtl/dpram_pkg.sv
// Shared constants and the byte-lane merge helper for the dual-port byte-enable RAM.
package dpram_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;
    localparam int PRIO_A          = 0;
    localparam int PRIO_B          = 1;

    // Widest word/lane count the merge helper handles; callers widen/narrow with casts.
    localparam int MAX_DATA  = 256;
    localparam int MAX_LANES = 256;
    localparam int LANE_IW   = $clog2(MAX_LANES);

    // Bytes whose enable is set come from new_w, the rest from old_w.
    function automatic logic [MAX_DATA-1:0] lane_merge(
        input logic [MAX_DATA-1:0]  old_w,
        input logic [MAX_DATA-1:0]  new_w,
        input logic [MAX_LANES-1:0] be,
        input int                   byte_w
    );
        logic [MAX_DATA-1:0] m;
        int                  lane;
        m = old_w;
        for (int i = 0; i < MAX_DATA; i++) begin
            lane = i / byte_w;
            if (lane < MAX_LANES && be[lane[LANE_IW-1:0]])
                m[i] = new_w[i];
        end
        return m;
    endfunction

endpackage

// File: rtl/dpram_be_out_pipe.sv
// Optional per-port output register: data/valid delayed one cycle, or wired straight through.
module dpram_out_pipe #(
    parameter int DATA    = 16,
    parameter int OUT_REG = 1
) (
    input  logic            clK,
    input  logic            rst_n,
    input  logic [DATA-1:0] i_data,
    input  logic            i_vld,
    output logic [DATA-1:0] o_data,
    output logic            o_vld
);

    generate
        if (OUT_REG != 0) begin : g_reg
            logic [DATA-1:0] r_data;
            logic            r_vld;

            // Extra timing stage; data only moves with a valid word so it holds otherwise.
            always_ff @(posedge clK or negedge rst_n) begin
                if (!rst_n) begin
                    r_data <= '0;
                    r_vld  <= 1'b0;
                end else begin
                    r_vld <= i_vld;
                    if (i_vld)
                        r_data <= i_data;
                end
            end

            assign o_data = r_data;
            assign o_vld  = r_vld;
        end else begin : g_byp
            logic w_unused;
            assign w_unused = clK ^ rst_n;
            assign o_data   = i_data;
            assign o_vld    = i_vld;
        end
    endgenerate

endmodule

// File: rtl/dpram_be.sv
// True dual-port RAM with per-lane byte enables, registered reads with valid strobes,
// selectable read-during-write view and same-address write arbitration with a monitor.
module dpram_be
    import dpram_pkg::*;
#(
    parameter int DATA      = 16,
    parameter int ADDR      = 5,
    parameter int BYTE      = 8,
    parameter int RDW_MODE  = 0,
    parameter int OUT_REG   = 1,
    parameter int COLL_PRIO = 0
) (
    input  logic                   clK,
    input  logic                   rst_n,
    input  logic                   a_port_EN,
    input  logic                   a_port_WR,
    input  logic [DATA/BYTE-1:0]   a_port_BE,
    input  logic [ADDR-1:0]        a_port_ADDR,
    input  logic [DATA-1:0]        a_port_data_IN,
    output logic [DATA-1:0]        a_port_data_OUT,
    output logic                   a_port_VALID,
    input  logic                   b_port_EN,
    input  logic                   b_port_WR,
    input  logic [DATA/BYTE-1:0]   b_port_BE,
    input  logic [ADDR-1:0]        b_port_ADDR,
    input  logic [DATA-1:0]        b_port_data_IN,
    output logic [DATA-1:0]        b_port_data_OUT,
    output logic                   b_port_VALID,
    output logic                   coll_FLAG,
    output logic [15:0]            coll_COUNT
);

    localparam int LANES = DATA / BYTE;
    localparam int DEPTH = 2 ** ADDR;

    logic [DATA-1:0]  r_mem [DEPTH];

    logic             w_a_wr, w_b_wr, w_coll;
    logic [LANES-1:0] w_a_be_wr, w_b_be_wr;
    logic [LANES-1:0] w_a_lane, w_b_lane;
    logic [DATA-1:0]  w_a_old, w_b_old, w_a_rd, w_b_rd;

    logic [DATA-1:0]  r_a_data, r_b_data;
    logic             r_a_vld, r_b_vld;
    logic             r_coll_flag;
    logic [15:0]      r_coll_cnt;

    // Writes are blocked while reset is held so an in-reset access never lands.
    assign w_a_wr    = a_port_EN & a_port_WR & rst_n;
    assign w_b_wr    = b_port_EN & b_port_WR & rst_n;
    assign w_a_be_wr = w_a_wr ? a_port_BE : '0;
    assign w_b_be_wr = w_b_wr ? b_port_BE : '0;
    assign w_coll    = w_a_wr & w_b_wr & (a_port_ADDR == b_port_ADDR);

    // Lane arbitration: on a same-address collision the losing port drops the shared lanes.
    always_comb begin
        w_a_lane = w_a_be_wr;
        w_b_lane = w_b_be_wr;
        if (w_coll) begin
            if (COLL_PRIO == PRIO_A)
                w_b_lane = w_b_be_wr & ~w_a_be_wr;
            else
                w_a_lane = w_a_be_wr & ~w_b_be_wr;
        end
    end

    // Memory write; lane masks are disjoint on a collision so both NBAs can coexist.
    always_ff @(posedge clK) begin
        for (int l = 0; l < LANES; l++) begin
            if (w_a_lane[l])
                r_mem[a_port_ADDR][l*BYTE +: BYTE] <= a_port_data_IN[l*BYTE +: BYTE];
        end
        for (int l = 0; l < LANES; l++) begin
            if (w_b_lane[l])
                r_mem[b_port_ADDR][l*BYTE +: BYTE] <= b_port_data_IN[l*BYTE +: BYTE];
        end
    end

    // Read view: pre-write word, or own-port write merged in for write-first (uses own BE,
    // not the arbitrated mask, so a losing port still sees its own write).
    assign w_a_old = r_mem[a_port_ADDR];
    assign w_b_old = r_mem[b_port_ADDR];
    assign w_a_rd  = (RDW_MODE == RDW_WRITE_FIRST)
                   ? DATA'(lane_merge(MAX_DATA'(w_a_old), MAX_DATA'(a_port_data_IN),
                                      MAX_LANES'(w_a_be_wr), BYTE))
                   : w_a_old;
    assign w_b_rd  = (RDW_MODE == RDW_WRITE_FIRST)
                   ? DATA'(lane_merge(MAX_DATA'(w_b_old), MAX_DATA'(b_port_data_IN),
                                      MAX_LANES'(w_b_be_wr), BYTE))
                   : w_b_old;

    // Port A registered read; every enabled access returns a word.
    always_ff @(posedge clK or negedge rst_n) begin
        if (!rst_n) begin
            r_a_data <= '0;
            r_a_vld  <= 1'b0;
        end else begin
            r_a_vld <= a_port_EN;
            if (a_port_EN)
                r_a_data <= w_a_rd;
        end
    end

    // Port B registered read.
    always_ff @(posedge clK or negedge rst_n) begin
        if (!rst_n) begin
            r_b_data <= '0;
            r_b_vld  <= 1'b0;
        end else begin
            r_b_vld <= b_port_EN;
            if (b_port_EN)
                r_b_data <= w_b_rd;
        end
    end

    // Collision monitor: one-cycle flag plus saturating event count.
    always_ff @(posedge clK or negedge rst_n) begin
        if (!rst_n) begin
            r_coll_flag <= 1'b0;
            r_coll_cnt  <= '0;
        end else begin
            r_coll_flag <= w_coll;
            if (w_coll && r_coll_cnt != 16'hFFFF)
                r_coll_cnt <= r_coll_cnt + 16'd1;
        end
    end

    assign coll_FLAG  = r_coll_flag;
    assign coll_COUNT = r_coll_cnt;

    dpram_out_pipe #(.DATA(DATA), .OUT_REG(OUT_REG)) u_pipe_a (
        .clK    (clK),
        .rst_n  (rst_n),
        .i_data (r_a_data),
        .i_vld  (r_a_vld),
        .o_data (a_port_data_OUT),
        .o_vld  (a_port_VALID)
    );

    dpram_out_pipe #(.DATA(DATA), .OUT_REG(OUT_REG)) u_pipe_b (
        .clK    (clK),
        .rst_n  (rst_n),
        .i_data (r_b_data),
        .i_vld  (r_b_vld),
        .o_data (b_port_data_OUT),
        .o_vld  (b_port_VALID)
    );

endmodule

// File: tb/tb_dpram_be.sv
// Directed bench: two instances share stimulus. d0 = read-first, OUT_REG=1, A priority;
// d1 = write-first, OUT_REG=0, B priority. Inputs change on the falling edge and outputs
// are sampled there too, so d1 shows an access one step later and d0 two steps later.
module tb_dpram_be;

    logic        clK;
    logic        rst_n;
    logic        a_en, a_wr, b_en, b_wr;
    logic [1:0]  a_be, b_be;
    logic [4:0]  a_addr, b_addr;
    logic [15:0] a_din, b_din;

    logic [15:0] d0_a_do, d0_b_do, d1_a_do, d1_b_do;
    logic        d0_a_v, d0_b_v, d1_a_v, d1_b_v;
    logic        d0_cf, d1_cf;
    logic [15:0] d0_cc, d1_cc;

    int n_asrt = 0;
    int n_fail = 0;

    dpram_be #(.DATA(16), .ADDR(5), .BYTE(8), .RDW_MODE(0), .OUT_REG(1), .COLL_PRIO(0)) d0 (
        .clK(clK), .rst_n(rst_n),
        .a_port_EN(a_en), .a_port_WR(a_wr), .a_port_BE(a_be), .a_port_ADDR(a_addr),
        .a_port_data_IN(a_din), .a_port_data_OUT(d0_a_do), .a_port_VALID(d0_a_v),
        .b_port_EN(b_en), .b_port_WR(b_wr), .b_port_BE(b_be), .b_port_ADDR(b_addr),
        .b_port_data_IN(b_din), .b_port_data_OUT(d0_b_do), .b_port_VALID(d0_b_v),
        .coll_FLAG(d0_cf), .coll_COUNT(d0_cc)
    );

    dpram_be #(.DATA(16), .ADDR(5), .BYTE(8), .RDW_MODE(1), .OUT_REG(0), .COLL_PRIO(1)) d1 (
        .clK(clK), .rst_n(rst_n),
        .a_port_EN(a_en), .a_port_WR(a_wr), .a_port_BE(a_be), .a_port_ADDR(a_addr),
        .a_port_data_IN(a_din), .a_port_data_OUT(d1_a_do), .a_port_VALID(d1_a_v),
        .b_port_EN(b_en), .b_port_WR(b_wr), .b_port_BE(b_be), .b_port_ADDR(b_addr),
        .b_port_data_IN(b_din), .b_port_data_OUT(d1_b_do), .b_port_VALID(d1_b_v),
        .coll_FLAG(d1_cf), .coll_COUNT(d1_cc)
    );

    initial clK = 1'b0;
    always #5 clK = ~clK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic ae, input logic aw, input logic [1:0] abe,
                       input logic [4:0] aad, input logic [15:0] ad,
                       input logic be_, input logic bw, input logic [1:0] bbe,
                       input logic [4:0] bad, input logic [15:0] bd);
        a_en = ae; a_wr = aw; a_be = abe; a_addr = aad; a_din = ad;
        b_en = be_; b_wr = bw; b_be = bbe; b_addr = bad; b_din = bd;
    endtask

    task automatic idle();
        drv(0, 0, 2'b00, 5'd0, 16'h0, 0, 0, 2'b00, 5'd0, 16'h0);
    endtask

    task automatic step();
        @(negedge clK);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        step();
        step();
        // Reset state
        chk("rst_d0_a_do", d0_a_do, 16'h0);
        chk("rst_d0_a_v",  d0_a_v, 1'b0);
        chk("rst_d0_b_v",  d0_b_v, 1'b0);
        chk("rst_d0_cf",   d0_cf, 1'b0);
        chk("rst_d0_cc",   d0_cc, 16'h0);
        chk("rst_d1_a_v",  d1_a_v, 1'b0);
        chk("rst_d1_b_do", d1_b_do, 16'h0);
        rst_n = 1'b1;

        // Preload whole array with zero
        for (int i = 0; i < 16; i++) begin
            drv(1, 1, 2'b11, 5'(i), 16'h0, 1, 1, 2'b11, 5'(i + 16), 16'h0);
            step();
        end
        idle(); step(); step();

        // Write A addr3, read B addr3 next cycle
        drv(1, 1, 2'b11, 5'd3, 16'hBEEF, 0, 0, 2'b00, 5'd0, 16'h0); step();
        chk("wr3_d1_a_v",  d1_a_v, 1'b1);
        chk("wr3_d1_a_do", d1_a_do, 16'hBEEF);
        chk("wr3_d1_b_v",  d1_b_v, 1'b0);
        drv(0, 0, 2'b00, 5'd0, 16'h0, 1, 0, 2'b00, 5'd3, 16'h0); step();
        chk("wr3_d0_a_v",  d0_a_v, 1'b1);
        chk("wr3_d0_a_do", d0_a_do, 16'h0000);
        chk("rd3_d1_b_do", d1_b_do, 16'hBEEF);
        chk("rd3_d1_a_v",  d1_a_v, 1'b0);
        idle(); step();
        chk("rd3_d0_b_v",  d0_b_v, 1'b1);
        chk("rd3_d0_b_do", d0_b_do, 16'hBEEF);
        chk("rd3_d0_a_v",  d0_a_v, 1'b0);
        step();
        chk("rd3_d0_b_pulse", d0_b_v, 1'b0);
        chk("rd3_d0_b_hold",  d0_b_do, 16'hBEEF);

        // Byte-enable write and read-during-write views
        drv(1, 1, 2'b11, 5'd5, 16'h1234, 0, 0, 2'b00, 5'd0, 16'h0); step();
        drv(1, 1, 2'b01, 5'd5, 16'hABCD, 0, 0, 2'b00, 5'd0, 16'h0); step();
        chk("be_d1_wf", d1_a_do, 16'h12CD);
        drv(1, 0, 2'b00, 5'd5, 16'h0, 0, 0, 2'b00, 5'd0, 16'h0); step();
        chk("be_d0_rf", d0_a_do, 16'h1234);
        chk("be_d1_rd", d1_a_do, 16'h12CD);
        idle(); step();
        chk("be_d0_rd", d0_a_do, 16'h12CD);

        // Full-overlap collision on addr 7
        drv(1, 1, 2'b11, 5'd7, 16'hAAAA, 1, 1, 2'b11, 5'd7, 16'h5555); step();
        chk("c1_d1_cf",   d1_cf, 1'b1);
        chk("c1_d1_cc",   d1_cc, 16'd1);
        chk("c1_d0_cf",   d0_cf, 1'b1);
        chk("c1_d0_cc",   d0_cc, 16'd1);
        chk("c1_d1_a_wf", d1_a_do, 16'hAAAA);
        chk("c1_d1_b_wf", d1_b_do, 16'h5555);
        drv(1, 0, 2'b00, 5'd7, 16'h0, 0, 0, 2'b00, 5'd0, 16'h0); step();
        chk("c1_d0_cf_pulse", d0_cf, 1'b0);
        chk("c1_d0_a_rf", d0_a_do, 16'h0000);
        chk("c1_d0_b_rf", d0_b_do, 16'h0000);
        chk("c1_d1_win",  d1_a_do, 16'h5555);
        // Disjoint-lane collision
        drv(1, 1, 2'b10, 5'd7, 16'hAAAA, 1, 1, 2'b01, 5'd7, 16'h5555); step();
        chk("c1_d0_win",  d0_a_do, 16'hAAAA);
        chk("c2_d1_cc",   d1_cc, 16'd2);
        chk("c2_d1_a_wf", d1_a_do, 16'hAA55);
        drv(1, 0, 2'b00, 5'd7, 16'h0, 0, 0, 2'b00, 5'd0, 16'h0); step();
        chk("c2_d0_cc",   d0_cc, 16'd2);
        chk("c2_d0_a_rf", d0_a_do, 16'hAAAA);
        chk("c2_d1_mem",  d1_a_do, 16'hAA55);
        idle(); step();
        chk("c2_d0_mem",  d0_a_do, 16'hAA55);

        // Cross-port read of a word being written by the other port
        drv(1, 1, 2'b11, 5'd9, 16'h0F0F, 1, 0, 2'b00, 5'd9, 16'h0); step();
        chk("x_d1_b_old", d1_b_do, 16'h0000);
        drv(0, 0, 2'b00, 5'd0, 16'h0, 1, 0, 2'b00, 5'd9, 16'h0); step();
        chk("x_d0_b_old", d0_b_do, 16'h0000);
        chk("x_d1_b_new", d1_b_do, 16'h0F0F);
        idle(); step();
        chk("x_d0_b_new", d0_b_do, 16'h0F0F);

        // Streaming: fill, then 32 back-to-back reads on both ports
        for (int i = 0; i < 32; i++) begin
            drv(1, 1, 2'b11, 5'(i), 16'hC000 | 16'(i), 0, 0, 2'b00, 5'd0, 16'h0);
            step();
        end
        for (int k = 0; k <= 32; k++) begin
            if (k < 32) drv(1, 0, 2'b00, 5'(k), 16'h0, 1, 0, 2'b00, 5'(31 - k), 16'h0);
            else        idle();
            step();
            if (k < 32) begin
                chk("st_d1_a_v",  d1_a_v, 1'b1);
                chk("st_d1_a_do", d1_a_do, 16'hC000 | 16'(k));
                chk("st_d1_b_do", d1_b_do, 16'hC000 | 16'(31 - k));
            end
            if (k > 0) begin
                chk("st_d0_a_v",  d0_a_v, 1'b1);
                chk("st_d0_b_v",  d0_b_v, 1'b1);
                chk("st_d0_a_do", d0_a_do, 16'hC000 | 16'(k - 1));
                chk("st_d0_b_do", d0_b_do, 16'hC000 | 16'(32 - k));
            end
        end
        step();
        chk("st_d0_a_end", d0_a_v, 1'b0);
        chk("st_d1_b_end", d1_b_v, 1'b0);

        // Reset with reads in flight
        drv(1, 0, 2'b00, 5'd3, 16'h0, 1, 0, 2'b00, 5'd9, 16'h0); step();
        drv(1, 0, 2'b00, 5'd5, 16'h0, 1, 0, 2'b00, 5'd7, 16'h0); step();
        chk("mr_pre_d0_a_v", d0_a_v, 1'b1);
        rst_n = 1'b0;
        idle();
        #1;
        chk("mr_d0_a_v",  d0_a_v, 1'b0);
        chk("mr_d0_b_v",  d0_b_v, 1'b0);
        chk("mr_d1_a_v",  d1_a_v, 1'b0);
        chk("mr_d0_a_do", d0_a_do, 16'h0);
        step(); step();
        rst_n = 1'b1;
        step();
        chk("mr_rel_d0_a_v", d0_a_v, 1'b0);
        chk("mr_rel_d1_b_v", d1_b_v, 1'b0);
        step();
        chk("mr_rel2_d0_b_v", d0_b_v, 1'b0);
        chk("mr_rel_d0_cc",   d0_cc, 16'h0);
        drv(1, 0, 2'b00, 5'd3, 16'h0, 1, 0, 2'b00, 5'd9, 16'h0); step();
        idle(); step();
        chk("mr_mem_a3", d0_a_do, 16'hC003);
        chk("mr_mem_b9", d0_b_do, 16'hC009);

        // Saturating collision counter
        drv(1, 1, 2'b11, 5'd0, 16'h1111, 1, 1, 2'b11, 5'd0, 16'h2222);
        repeat (65534) step();
        chk("sat_d0_fffe", d0_cc, 16'hFFFE);
        chk("sat_d1_fffe", d1_cc, 16'hFFFE);
        step();
        chk("sat_d0_ffff", d0_cc, 16'hFFFF);
        step();
        chk("sat_d0_hold", d0_cc, 16'hFFFF);
        chk("sat_d1_hold", d1_cc, 16'hFFFF);
        chk("sat_d0_cf",   d0_cf, 1'b1);
        idle(); step();
        chk("sat_d0_cf_off", d0_cf, 1'b0);
        chk("sat_d0_final",  d0_cc, 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
